// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser plus per-channel debounce FSM with press/release pulses.
// Optional auto-repeat on held buttons is enabled by defining BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce #(
    parameter int unsigned NUM_BUTTONS   = 5,
    parameter logic [26:0] COUNT_STABLE  = 27'd763_932,
    parameter logic        PRESSED_LEVEL = 1'b1,
    parameter logic [26:0] REPEAT_DELAY  = 27'd19_098_300,
    parameter logic [26:0] REPEAT_PERIOD = 27'd3_819_660
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    localparam int unsigned CNT_W = 27;
    localparam logic [CNT_W-1:0] COUNT_LAST = COUNT_STABLE - CNT_W'(1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Elaboration-time guards on the configuration
    if (COUNT_STABLE == 27'd0) begin : g_bad_count
        $error("button_debounce: COUNT_STABLE must be at least 1");
    end
    if (NUM_BUTTONS < 1 || NUM_BUTTONS > 16) begin : g_bad_width
        $error("button_debounce: NUM_BUTTONS must be 1..16");
    end
    if (REPEAT_DELAY == 27'd0 || REPEAT_PERIOD == 27'd0) begin : g_bad_repeat
        $error("button_debounce: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
    end

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] sync_n;

    // Two-flop synchroniser; idles at the released pin level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= {NUM_BUTTONS{~PRESSED_LEVEL}};
            sync2 <= {NUM_BUTTONS{~PRESSED_LEVEL}};
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign sync_n = PRESSED_LEVEL ? sync2 : ~sync2;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_next;
        logic             level_q;
        logic             level_next;
        logic             press_q;
        logic             press_next;
        logic             release_q;
        logic             release_next;
        logic             mismatch;
        logic             do_flip;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        logic [CNT_W-1:0] hold;
        logic [CNT_W-1:0] hold_next;
`endif

        assign mismatch = (sync_n[i] != level_q);

        always_comb begin
            state_next   = state;
            count_next   = count;
            level_next   = level_q;
            press_next   = 1'b0;
            release_next = 1'b0;
            do_flip      = 1'b0;
            case (state)
                ST_STABLE: begin
                    if (mismatch) begin
                        if (count == COUNT_LAST) begin
                            do_flip = 1'b1;
                        end else begin
                            count_next = count + CNT_W'(1);
                            state_next = ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!mismatch) begin
                        count_next = '0;
                        state_next = ST_STABLE;
                    end else if (count == COUNT_LAST) begin
                        do_flip = 1'b1;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
                default: begin
                    count_next = '0;
                    state_next = ST_STABLE;
                end
            endcase
            if (do_flip) begin
                level_next   = sync_n[i];
                count_next   = '0;
                state_next   = ST_STABLE;
                press_next   = sync_n[i];
                release_next = ~sync_n[i];
            end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            // Hold counter folds back to REPEAT_DELAY after each periodic repeat
            hold_next = '0;
            if (level_q && !do_flip) begin
                hold_next = hold + CNT_W'(1);
                if (hold_next == REPEAT_DELAY) begin
                    press_next = 1'b1;
                end else if ({1'b0, hold_next} == ((CNT_W+1)'(REPEAT_DELAY) + (CNT_W+1)'(REPEAT_PERIOD))) begin
                    press_next = 1'b1;
                    hold_next  = REPEAT_DELAY;
                end
            end
`endif
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state     <= ST_STABLE;
                count     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                hold      <= '0;
`endif
            end else begin
                state     <= state_next;
                count     <= count_next;
                level_q   <= level_next;
                press_q   <= press_next;
                release_q <= release_next;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
                hold      <= hold_next;
`endif
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: reset, clean press, bounce, glitch, simultaneous
// channels, async reset and long hold (auto-repeat expectations follow BUTTON_DEBOUNCE_REPEAT_EN).
module tb_button_debounce;

    localparam int unsigned NB = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int n_cmp  = 0;
    int n_fail = 0;

    int press_cnt [NB];
    int release_cnt [NB];
    int overlap_cnt = 0;
    int snap_p [NB];
    int snap_r [NB];

    button_debounce #(
        .NUM_BUTTONS  (NB),
        .COUNT_STABLE (27'd4),
        .PRESSED_LEVEL(1'b1),
        .REPEAT_DELAY (27'd10),
        .REPEAT_PERIOD(27'd3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < int'(NB); i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
    end

    // Pulse tally sampled mid-cycle, away from the active edge
    always @(negedge clock) begin
        for (int i = 0; i < int'(NB); i++) begin
            press_cnt[i]   = press_cnt[i] + int'(btn_press[i]);
            release_cnt[i] = release_cnt[i] + int'(btn_release[i]);
        end
        if ((btn_press & btn_release) != '0) overlap_cnt = overlap_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (got === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < int'(NB); i++) begin
            snap_p[i] = press_cnt[i];
            snap_r[i] = release_cnt[i];
        end
    endtask

    initial begin
        int exp_hold_presses;
        logic exp_repeat_pulse;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        exp_hold_presses = 8;
        exp_repeat_pulse = 1'b1;
`else
        exp_hold_presses = 1;
        exp_repeat_pulse = 1'b0;
`endif
        // Reset and idle
        step(3);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        reset = 1'b1;
        step(50);
        check("idle_level", 32'(btn_level), 32'h0);
        check("idle_presses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4]), 32'h0);
        check("idle_releases", 32'(release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3] + release_cnt[4]), 32'h0);

        // Clean press and release on channel 0: 6 edges of latency
        btn_raw = 5'b00001;
        step(5);
        check("press0_early", 32'(btn_level), 32'h0);
        step(1);
        check("press0_level", 32'(btn_level), 32'h01);
        check("press0_pulse", 32'(btn_press), 32'h01);
        check("press0_norel", 32'(btn_release), 32'h0);
        step(1);
        check("press0_width", 32'(btn_press), 32'h0);
        check("press0_hold", 32'(btn_level), 32'h01);
        btn_raw = 5'b00000;
        step(5);
        check("rel0_early", 32'(btn_level), 32'h01);
        step(1);
        check("rel0_level", 32'(btn_level), 32'h0);
        check("rel0_pulse", 32'(btn_release), 32'h01);
        check("rel0_nopress", 32'(btn_press), 32'h0);
        step(1);
        check("rel0_width", 32'(btn_release), 32'h0);

        // Asynchronous reset while a channel is held
        btn_raw = 5'b00001;
        step(6);
        check("arst_pre", 32'(btn_level), 32'h01);
        #2;
        reset = 1'b0;
        #1;
        check("arst_level", 32'(btn_level), 32'h0);
        check("arst_press", 32'(btn_press), 32'h0);
        step(2);
        reset = 1'b1;
        step(5);
        check("arst_repress_early", 32'(btn_level), 32'h0);
        step(1);
        check("arst_repress", 32'(btn_press), 32'h01);
        // Reset in the middle of a pending release discards it
        btn_raw = 5'b00000;
        step(4);
        snapshot();
        #2;
        reset = 1'b0;
        #1;
        check("pend_rst_level", 32'(btn_level), 32'h0);
        step(1);
        reset = 1'b1;
        step(12);
        check("pend_rst_presses", 32'(press_cnt[0] - snap_p[0]), 32'h0);
        check("pend_rst_releases", 32'(release_cnt[0] - snap_r[0]), 32'h0);

        // Bounce on channel 1: only the final stable rise counts
        snapshot();
        btn_raw = 5'b00010; step(2);
        btn_raw = 5'b00000; step(2);
        btn_raw = 5'b00010; step(2);
        btn_raw = 5'b00000; step(2);
        btn_raw = 5'b00010;
        step(5);
        check("bounce_early", 32'(btn_level), 32'h0);
        step(1);
        check("bounce_press", 32'(btn_press), 32'h02);
        check("bounce_level", 32'(btn_level), 32'h02);
        step(1);
        btn_raw = 5'b00000;
        step(8);
        check("bounce_npress", 32'(press_cnt[1] - snap_p[1]), 32'h1);
        check("bounce_nrelease", 32'(release_cnt[1] - snap_r[1]), 32'h1);

        // Glitch: three cycles high is one short of the threshold
        snapshot();
        btn_raw = 5'b00100;
        step(3);
        btn_raw = 5'b00000;
        step(10);
        check("glitch_level", 32'(btn_level), 32'h0);
        check("glitch_press", 32'(press_cnt[2] - snap_p[2]), 32'h0);
        check("glitch_release", 32'(release_cnt[2] - snap_r[2]), 32'h0);

        // Simultaneous press and release on channels 3 and 4
        btn_raw = 5'b11000;
        step(5);
        check("simul_early", 32'(btn_level), 32'h0);
        step(1);
        check("simul_press", 32'(btn_press), 32'h18);
        check("simul_level", 32'(btn_level), 32'h18);
        check("simul_norel", 32'(btn_release), 32'h0);
        step(14);
        btn_raw = 5'b00000;
        step(5);
        check("simul_rel_early", 32'(btn_release), 32'h0);
        step(1);
        check("simul_release", 32'(btn_release), 32'h18);
        check("simul_rel_level", 32'(btn_level), 32'h0);
        check("simul_rel_nopress", 32'(btn_press), 32'h0);

        // Long 30-cycle hold on channel 0
        snapshot();
        btn_raw = 5'b00001;
        step(6);
        check("hold_press", 32'(btn_press), 32'h01);
        step(10);
        check("hold_repeat1", 32'(btn_press[0]), 32'(exp_repeat_pulse));
        step(14);
        btn_raw = 5'b00000;
        step(10);
        check("hold_npress", 32'(press_cnt[0] - snap_p[0]), 32'(exp_hold_presses));
        check("hold_nrelease", 32'(release_cnt[0] - snap_r[0]), 32'h1);
        check("hold_level", 32'(btn_level), 32'h0);

        check("press_release_overlap", 32'(overlap_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Board-input counterpart to the LED output driver: samples NUM_BUTTONS raw push-button/switch pins, synchronises them into the clock domain, debounces each channel independently, and emits a clean level plus one-cycle press/release pulses.
- Sits between top-level pins and any control logic, for example an LED pattern selector or step/pause control.
- Same board clock as the LED driver; all timing is expressed in clock cycles.

Parameters:
- NUM_BUTTONS, 5, number of independent input channels (1..16).
- COUNT_STABLE, 27'd763_932, consecutive cycles a synchronised input must differ from the debounced level before the level flips (~20 ms at 38.1966 MHz); legal range 1..2^27-1.
- PRESSED_LEVEL, 1'b1, raw pin level meaning "pressed"; 1'b0 for pull-up boards.
- REPEAT_DELAY, 27'd19_098_300, hold time before auto-repeat starts (used only with the optional feature).
- REPEAT_PERIOD, 27'd3_819_660, auto-repeat interval (used only with the optional feature).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; all state clears immediately when low.
- btn_raw  input  NUM_BUTTONS  raw, asynchronous pin levels.
- btn_level  output  NUM_BUTTONS  debounced state per channel; 1 = pressed, regardless of PRESSED_LEVEL.
- btn_press  output  NUM_BUTTONS  one-cycle pulse on each debounced press (and on auto-repeat, if enabled).
- btn_release  output  NUM_BUTTONS  one-cycle pulse on each debounced release.

Behaviour:
- Reset (reset low, asynchronous):
  - Both synchroniser stages load the released level (~PRESSED_LEVEL).
  - All counters clear to 0.
  - btn_level, btn_press and btn_release are all 0.
  - Release is synchronous to clock; the first sampling edge is the first rising edge with reset high.
- Synchroniser: two flops per channel. sync_n = (stage2 == PRESSED_LEVEL), giving a normalised pressed flag.
- Per-channel debounce FSM, two states:
  - STABLE: sync_n == btn_level, count held at 0.
  - PENDING: sync_n != btn_level. Each cycle in PENDING, count increments by 1 (27-bit).
  - PENDING -> STABLE on bounce: if sync_n returns to btn_level, count clears to 0 on that edge and no output changes.
  - PENDING -> STABLE on flip: if count == COUNT_STABLE-1 and the mismatch persists, then on the same edge btn_level <= sync_n, count <= 0, and btn_press (0->1) or btn_release (1->0) is 1 for exactly the next cycle.
  - COUNT_STABLE=1: flip occurs on the first mismatched cycle.
- Latency: a clean raw edge reaches btn_level 2 + COUNT_STABLE rising edges later. The press/release pulse is coincident with the first cycle of the new btn_level.
- Pulse rules:
  - btn_press and btn_release are never both high on the same channel.
  - A pulse never exceeds 1 cycle.
  - Channels are fully independent; simultaneous flips on several channels pulse together.
- Count never wraps: it is bounded by COUNT_STABLE-1 and clears on every exit from PENDING.
- Reset asserted mid-PENDING discards the partial count; no pulse is emitted.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_REPEAT_EN.
- Defined:
  - Each channel has a second 27-bit hold counter that runs while btn_level==1 and clears on release or reset.
  - The first repeat btn_press fires when the hold counter reaches REPEAT_DELAY.
  - Further repeats fire every REPEAT_PERIOD cycles thereafter while still held.
  - A release during the hold cancels repeats; btn_release behaves as normal.
- Undefined:
  - No hold counter is instantiated.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - btn_press fires only once per debounced press.

Test Plan (bench uses COUNT_STABLE=4, NUM_BUTTONS=5, PRESSED_LEVEL=1, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset then idle, btn_raw=5'b00000 for 50 cycles -> btn_level=0, no pulses. Assert reset mid-run -> outputs 0 immediately, without waiting for a clock edge.
- Clean press: btn_raw[0] 0->1 at edge t -> btn_level[0]=1 and btn_press[0]=1 at edge t+6. Pulse lasts exactly 1 cycle; btn_release stays 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 with 2-cycle spacing, then holds 1 -> exactly one btn_press[1], 6 edges after the final rising transition.
- Glitch: btn_raw[2] high for 3 cycles, then low -> no change on btn_level[2], btn_press or btn_release.
- Simultaneous: btn_raw[3] and btn_raw[4] press on the same edge, release 20 cycles later -> press pulses coincident; release pulses coincident, 20 cycles after the press pulses.
- With BUTTON_DEBOUNCE_REPEAT_EN defined, btn_raw[0] held for 30 cycles -> btn_press[0] at the debounced press, then 10, 13, 16... cycles after it, stopping at release.
- Without BUTTON_DEBOUNCE_REPEAT_EN, the same 30-cycle hold -> exactly one btn_press[0].
